// File: rtl/steer_en_gen_pkg.sv
// steer_pkg: shared state type, default thresholds and settle constants for steer_en_gen.
package steer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } steer_state_t;

    // Default rider-present weight on the summed load and its hysteresis band.
    localparam int DEF_MIN_RIDER_WT = 32'sh0000_0200;
    localparam int DEF_WT_HYST      = 32'sh0000_0040;

    // Shortened settle length used when FAST_SIM is set.
    localparam int FAST_SETTLE_CYC  = 32'sd16384;

    // Width of a counter holding n distinct values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 32'sd1) begin
            return $clog2(n);
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/steer_en_gen_if.sv
// steer_en_gen_if: load-cell inputs and rider/steer status outputs of the controller.
interface steer_en_gen_if #(
    parameter int LD_W = 12
);
    logic signed [LD_W-1:0] lft_ld;
    logic signed [LD_W-1:0] rght_ld;
    logic                   en_steer;
    logic                   rider_off;
    logic [1:0]             state;

    // Load-cell side: drives loads, observes status.
    modport master (
        output lft_ld,
        output rght_ld,
        input  en_steer,
        input  rider_off,
        input  state
    );

    // Controller side: consumes loads, produces status.
    modport slave (
        input  lft_ld,
        input  rght_ld,
        output en_steer,
        output rider_off,
        output state
    );
endinterface

// File: rtl/steer_en_gen_settle_tmr.sv
// settle_tmr: up-counter that raises done at its terminal count; clr wins over run.
module settle_tmr #(
    parameter int WIDTH = 14,
    parameter int TERM  = 16383
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic done
);
    localparam logic [WIDTH-1:0] TERM_C = WIDTH'(TERM);
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(32'd1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear has priority, otherwise advance while running, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == TERM_C);

endmodule

// File: rtl/steer_en_gen.sv
// steer_en_gen: rider-presence detection and steering enable after a balanced settle period.
module steer_en_gen
    import steer_pkg::*;
#(
    parameter int LD_W         = 12,
    parameter int MIN_RIDER_WT = DEF_MIN_RIDER_WT,
    parameter int WT_HYST      = DEF_WT_HYST,
    parameter int ENTRY_SHF    = 32'sd2,
    parameter int EXIT_SHF     = 32'sd4,
    parameter int SETTLE_CYC   = 32'sd67_108_864,
    parameter bit FAST_SIM     = 1'b0,
    parameter int OFF_DLY      = 32'sd4
) (
    input  logic          clk,
    input  logic          rst_n,
    steer_en_gen_if.slave bus
);
    // Two guard bits keep sum, difference and its magnitude exact.
    localparam int W      = LD_W + 32'sd2;
    localparam int SETTLE = (FAST_SIM != 1'b0) ? FAST_SETTLE_CYC : SETTLE_CYC;
    localparam int TW     = cnt_width(SETTLE);
    localparam int OW     = cnt_width(OFF_DLY + 32'sd1);

    localparam logic signed [W-1:0] TH_ON    = W'(MIN_RIDER_WT + WT_HYST);
    localparam logic signed [W-1:0] TH_OFF   = W'(MIN_RIDER_WT - WT_HYST);
    localparam logic [OW-1:0]       OFF_LAST = OW'(OFF_DLY - 32'sd1);
    localparam logic [OW-1:0]       OFF_ONE  = OW'(32'd1);

    logic signed [W-1:0] lft_s;
    logic signed [W-1:0] rght_s;
    logic signed [W-1:0] sum_s;
    logic signed [W-1:0] diff_s;
    logic signed [W-1:0] adiff_s;
    logic signed [W-1:0] entry_lim_s;
    logic signed [W-1:0] exit_lim_s;
    logic                sum_gt_s;
    logic                sum_lt_s;
    logic                imbal_s;
    logic                lean_exit_s;

    steer_state_t        state_q;
    steer_state_t        state_d;
    logic [OW-1:0]       off_cnt_q;
    logic [OW-1:0]       off_cnt_d;
    logic                en_steer_q;
    logic                en_steer_d;
    logic                rider_off_q;
    logic                rider_off_d;

    logic                tmr_clr_s;
    logic                tmr_run_s;
    logic                tmr_done_s;

    // Load arithmetic and rider/balance flags, all signed at W bits.
    always_comb begin
        lft_s  = {{2{bus.lft_ld[LD_W-1]}}, bus.lft_ld};
        rght_s = {{2{bus.rght_ld[LD_W-1]}}, bus.rght_ld};
        sum_s  = lft_s + rght_s;
        diff_s = lft_s - rght_s;
        if (diff_s[W-1]) begin
            adiff_s = -diff_s;
        end else begin
            adiff_s = diff_s;
        end
        entry_lim_s = sum_s >>> ENTRY_SHF;
        exit_lim_s  = sum_s - (sum_s >>> EXIT_SHF);
        sum_gt_s    = (sum_s > TH_ON);
        sum_lt_s    = (sum_s < TH_OFF);
        imbal_s     = (adiff_s > entry_lim_s);
        lean_exit_s = (adiff_s > exit_lim_s);
    end

    // Next state, off-debounce count, settle timer control and output decode.
    always_comb begin
        state_d   = state_q;
        off_cnt_d = '0;
        tmr_clr_s = 1'b1;
        tmr_run_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (sum_gt_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (sum_lt_s) begin
                    state_d = IDLE;
                end else if (imbal_s) begin
                    // Any imbalance restarts the settle period, even on terminal count.
                    state_d = WAIT;
                end else if (tmr_done_s) begin
                    state_d = STEER;
                end else begin
                    state_d   = WAIT;
                    tmr_clr_s = 1'b0;
                    tmr_run_s = 1'b1;
                end
            end
            STEER: begin
                if (sum_lt_s) begin
                    // Low weight masks lean exit; only a full debounce run drops the rider.
                    if (off_cnt_q == OFF_LAST) begin
                        state_d   = IDLE;
                        off_cnt_d = '0;
                    end else begin
                        state_d   = STEER;
                        off_cnt_d = off_cnt_q + OFF_ONE;
                    end
                end else if (lean_exit_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = STEER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        en_steer_d  = (state_d == STEER);
        rider_off_d = (state_d == IDLE);
    end

    // State, debounce counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            off_cnt_q   <= '0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            off_cnt_q   <= off_cnt_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
        end
    end

    settle_tmr #(
        .WIDTH (TW),
        .TERM  (SETTLE - 32'sd1)
    ) u_settle_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .run   (tmr_run_s),
        .done  (tmr_done_s)
    );

    assign bus.en_steer  = en_steer_q;
    assign bus.rider_off = rider_off_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_steer_en_gen.sv
// tb_steer_en_gen: directed test-plan steps plus randomized loads against a behavioural model.
module tb_steer_en_gen;

    localparam int SETTLE = 16384;
    localparam int OFF    = 4;
    localparam int TH_ON  = 'h240;
    localparam int TH_OFF = 'h1C0;

    logic clk;
    logic rst_n;
    steer_en_gen_if #(.LD_W(12)) bus ();

    steer_en_gen #(.FAST_SIM(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int lft_v    = 0;
    int rght_v   = 0;

    // Behavioural model: state, edge count, edge of last settle restart, low-weight streak.
    int m_state = 0;
    int ncyc    = 0;
    int m_ref   = 0;
    int m_low   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ld(input int l, input int r);
        lft_v  = l;
        rght_v = r;
        bus.lft_ld  = 12'(l);
        bus.rght_ld = 12'(r);
    endtask

    task automatic model_step();
        int s, d, ad;
        bit gt, lt, imb, lean;
        ncyc++;
        s    = lft_v + rght_v;
        d    = lft_v - rght_v;
        ad   = (d < 0) ? -d : d;
        gt   = s > TH_ON;
        lt   = s < TH_OFF;
        imb  = ad > (s >>> 2);
        lean = ad > (s - (s >>> 4));
        if (!rst_n) begin
            m_state = 0;
            m_low   = 0;
        end else begin
            case (m_state)
                0: if (gt) begin m_state = 1; m_ref = ncyc; end
                1: begin
                    if (lt) m_state = 0;
                    else if (imb) m_ref = ncyc;
                    else if (ncyc - m_ref == SETTLE) begin m_state = 2; m_low = 0; end
                end
                2: begin
                    if (lt) begin
                        m_low++;
                        if (m_low == OFF) begin m_state = 0; m_low = 0; end
                    end else begin
                        m_low = 0;
                        if (lean) begin m_state = 1; m_ref = ncyc; end
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_state", {30'b0, bus.state}, 32'(m_state));
        chk("model_en_steer", {31'b0, bus.en_steer}, {31'b0, m_state == 2});
        chk("model_rider_off", {31'b0, bus.rider_off}, {31'b0, m_state == 0});
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        set_ld(0, 0);
        tick_n(2);
        chk("rst_state", {30'b0, bus.state}, 32'd0);
        chk("rst_rider_off", {31'b0, bus.rider_off}, 32'd1);
        chk("rst_en_steer", {31'b0, bus.en_steer}, 32'd0);

        // 1. settle from IDLE
        rst_n = 1'b1;
        set_ld('h150, 'h150);
        tick();
        chk("s1_wait", {30'b0, bus.state}, 32'd1);
        tick_n(SETTLE - 1);
        chk("s1_not_yet", {31'b0, bus.en_steer}, 32'd0);
        tick();
        chk("s1_en_steer", {31'b0, bus.en_steer}, 32'd1);
        chk("s1_rider_on", {31'b0, bus.rider_off}, 32'd0);

        // 3. lean exit
        set_ld('h290, 'h10);
        tick();
        chk("s3_wait", {30'b0, bus.state}, 32'd1);
        chk("s3_en_low", {31'b0, bus.en_steer}, 32'd0);

        // 2. imbalance restart in WAIT
        set_ld('h150, 'h150);
        tick_n(100);
        set_ld('h200, 'hA0);
        tick();
        chk("s2_imb_wait", {30'b0, bus.state}, 32'd1);
        set_ld('h150, 'h150);
        tick_n(SETTLE - 1);
        chk("s2_not_early", {31'b0, bus.en_steer}, 32'd0);
        tick();
        chk("s2_en_steer", {31'b0, bus.en_steer}, 32'd1);

        // 4. off debounce
        set_ld('hD0, 'hD0);
        tick_n(3);
        chk("s4_hold3", {30'b0, bus.state}, 32'd2);
        set_ld('h150, 'h150);
        tick();
        chk("s4_gap", {30'b0, bus.state}, 32'd2);
        set_ld('hD0, 'hD0);
        tick_n(3);
        chk("s4_hold_again", {30'b0, bus.state}, 32'd2);
        tick();
        chk("s4_idle", {30'b0, bus.state}, 32'd0);
        chk("s4_rider_off", {31'b0, bus.rider_off}, 32'd1);

        // 5. hysteresis and reset mid-WAIT
        set_ld('h100, 'h100);
        tick_n(10);
        chk("s5_hyst_idle", {30'b0, bus.state}, 32'd0);
        set_ld('h150, 'h150);
        tick();
        chk("s5_wait", {30'b0, bus.state}, 32'd1);
        set_ld('h100, 'h100);
        tick_n(20);
        chk("s5_hyst_wait", {30'b0, bus.state}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("s5_rst_idle", {30'b0, bus.state}, 32'd0);
        chk("s5_rst_rider_off", {31'b0, bus.rider_off}, 32'd1);
        rst_n = 1'b1;
        set_ld('h150, 'h150);
        tick();
        tick_n(SETTLE - 1);
        chk("s5_timer_zeroed", {31'b0, bus.en_steer}, 32'd0);
        tick();
        chk("s5_en_steer", {31'b0, bus.en_steer}, 32'd1);

        // Randomized loads from STEER, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            int mode;
            mode  = int'($urandom_range(0, 9));
            rst_n = ($urandom_range(0, 199) != 0);
            if (mode <= 4) begin
                set_ld(int'($urandom_range('hC0, 'h180)), int'($urandom_range('hC0, 'h180)));
            end else if (mode <= 7) begin
                set_ld(int'($urandom_range('h200, 'h300)), int'($urandom_range(0, 'h80)) - 'h40);
            end else if (mode == 8) begin
                set_ld(int'($urandom_range(0, 'h80)), int'($urandom_range(0, 'h80)));
            end else begin
                set_ld(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
